// File: rtl/axi_ni_response_pinout_buf.sv
// NI response pinout buffer: steers depacketized response beats onto AXI R/B with 2-entry FIFOs.
// Optional macro AXI_NI_RESP_ERR_COUNT_EN adds a saturating popped-SLVERR counter (err_count).

`ifndef PACKETRESPONSEWD
`define PACKETRESPONSEWD 2
`endif
`ifndef PACKETTRANSIDWD
`define PACKETTRANSIDWD 8
`endif
`ifndef PACKETRESPONSE_DVA
`define PACKETRESPONSE_DVA 0
`endif
`ifndef PACKETRESPONSE_FAIL
`define PACKETRESPONSE_FAIL 1
`endif

// Small synchronous FIFO whose head is read straight from the storage registers.
module axi_ni_resp_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign valid = (count != '0);
  assign full  = (count == (AW+1)'(DEPTH));
endmodule

module axi_ni_response_pinout_buf #(
  parameter int unsigned AXIRDATAWD = 32,
  parameter int unsigned AXIIDWD    = 4,
  parameter int unsigned LENWD      = 8,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_mask,
  input  logic                        in_is_read,
  input  logic                        in_locked,
  input  logic [`PACKETRESPONSEWD-1:0] in_resp,
  input  logic [`PACKETTRANSIDWD-1:0]  in_id,
  input  logic [AXIRDATAWD-1:0]       in_data,
  input  logic [LENWD-1:0]            in_len,
  output logic [AXIIDWD-1:0]          RID,
  output logic [AXIRDATAWD-1:0]       RDATA,
  output logic [1:0]                  RRESP,
  output logic                        RLAST,
  output logic                        RVALID,
  input  logic                        RREADY,
  output logic [AXIIDWD-1:0]          BID,
  output logic [1:0]                  BRESP,
  output logic                        BVALID,
  input  logic                        BREADY
`ifdef AXI_NI_RESP_ERR_COUNT_EN
  ,
  output logic [15:0]                 err_count
`endif
);
  localparam int unsigned RESPWD = `PACKETRESPONSEWD;
  localparam int unsigned RW     = AXIIDWD + AXIRDATAWD + 3;
  localparam int unsigned BW     = AXIIDWD + 2;
  localparam logic [RESPWD-1:0] RESP_DVA  = RESPWD'(`PACKETRESPONSE_DVA);
  localparam logic [RESPWD-1:0] RESP_FAIL = RESPWD'(`PACKETRESPONSE_FAIL);
  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

  logic [1:0]         axi_resp;
  logic [AXIIDWD-1:0] axi_id;
  logic [LENWD-1:0]   cnt_q;
  logic [LENWD-1:0]   len_q;
  logic [LENWD-1:0]   cur_len;
  logic               rlast;
  logic               accept;
  logic               r_push, b_push, r_pop, b_pop;
  logic               r_full, b_full;
  logic [RW-1:0]      r_din, r_dout;
  logic [BW-1:0]      b_din, b_dout;

  // Packet response code to AXI response; FAIL is a failed exclusive, reported as OKAY.
  always_comb begin
    axi_resp = AXI_SLVERR;
    if (in_resp == RESP_DVA)       axi_resp = in_locked ? AXI_EXOKAY : AXI_OKAY;
    else if (in_resp == RESP_FAIL) axi_resp = AXI_OKAY;
  end

  assign axi_id   = AXIIDWD'(in_id);
  assign in_ready = in_mask | (in_is_read ? ~r_full : ~b_full);
  assign accept   = in_valid & in_ready & ~in_mask;
  assign r_push   = accept & in_is_read;
  assign b_push   = accept & ~in_is_read;
  assign r_pop    = RVALID & RREADY;
  assign b_pop    = BVALID & BREADY;

  // Burst length is only carried on the first beat; later beats use the latched copy.
  assign cur_len = (cnt_q == '0) ? in_len : len_q;
  assign rlast   = (cnt_q == cur_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      len_q <= '0;
    end else if (r_push) begin
      if (cnt_q == '0) len_q <= in_len;
      cnt_q <= rlast ? '0 : cnt_q + LENWD'(1);
    end
  end

  assign r_din = {axi_id, in_data, axi_resp, rlast};
  assign b_din = {axi_id, axi_resp};

  axi_ni_resp_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_r_fifo (
    .clk(clk), .rst(rst), .push(r_push), .din(r_din), .pop(r_pop),
    .dout(r_dout), .valid(RVALID), .full(r_full)
  );

  axi_ni_resp_fifo #(.W(BW), .DEPTH(FIFO_DEPTH)) u_b_fifo (
    .clk(clk), .rst(rst), .push(b_push), .din(b_din), .pop(b_pop),
    .dout(b_dout), .valid(BVALID), .full(b_full)
  );

  assign {RID, RDATA, RRESP, RLAST} = r_dout;
  assign {BID, BRESP}               = b_dout;

`ifdef AXI_NI_RESP_ERR_COUNT_EN
  logic [15:0] err_q;
  logic [16:0] err_sum;

  // Both channels may pop SLVERR in one cycle, so the increment can be 2.
  assign err_sum = {1'b0, err_q}
                 + 17'(r_pop & (RRESP == AXI_SLVERR))
                 + 17'(b_pop & (BRESP == AXI_SLVERR));

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  assign err_count = err_q;
`endif
endmodule

// File: tb/tb_axi_ni_response_pinout_buf.sv
// Directed self-checking bench for axi_ni_response_pinout_buf (R/B steering, RLAST, back-pressure, reset).
// Build with AXI_NI_RESP_ERR_COUNT_EN defined to also check err_count.

`ifndef PACKETRESPONSE_DVA
`define PACKETRESPONSE_DVA 0
`endif
`ifndef PACKETRESPONSE_FAIL
`define PACKETRESPONSE_FAIL 1
`endif

module tb_axi_ni_response_pinout_buf;
  localparam int unsigned DW   = 32;
  localparam int unsigned IDW  = 4;
  localparam int unsigned LW   = 8;
  localparam int unsigned RSPW = 2;
  localparam int unsigned PIDW = 8;
  localparam logic [RSPW-1:0] DVA  = RSPW'(`PACKETRESPONSE_DVA);
  localparam logic [RSPW-1:0] FAIL = RSPW'(`PACKETRESPONSE_FAIL);

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, in_mask, in_is_read, in_locked;
  logic [RSPW-1:0] in_resp;
  logic [PIDW-1:0] in_id;
  logic [DW-1:0]   in_data;
  logic [LW-1:0]   in_len;
  logic [IDW-1:0]  RID, BID;
  logic [DW-1:0]   RDATA;
  logic [1:0]      RRESP, BRESP;
  logic            RLAST, RVALID, RREADY, BVALID, BREADY;
`ifdef AXI_NI_RESP_ERR_COUNT_EN
  logic [15:0]     err_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_ni_response_pinout_buf #(
    .AXIRDATAWD(DW), .AXIIDWD(IDW), .LENWD(LW), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
    .in_is_read(in_is_read), .in_locked(in_locked), .in_resp(in_resp),
    .in_id(in_id), .in_data(in_data), .in_len(in_len),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
`ifdef AXI_NI_RESP_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  task automatic idle_inputs();
    in_valid = 1'b0; in_mask = 1'b0; in_is_read = 1'b0; in_locked = 1'b0;
    in_resp = DVA; in_id = '0; in_data = '0; in_len = '0;
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({RVALID, BVALID, RID, RDATA, RRESP, RLAST, BID, BRESP} !== '0) begin
      errors++;
      $display("FAIL %s: RVALID=%b BVALID=%b RID=%h RDATA=%h RRESP=%b RLAST=%b BID=%h BRESP=%b, all required 0",
               name, RVALID, BVALID, RID, RDATA, RRESP, RLAST, BID, BRESP);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; RREADY = 1'b0; BREADY = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_outputs_zero("reset_outputs");
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready);
    end
`ifdef AXI_NI_RESP_ERR_COUNT_EN
    checks++;
    if (err_count !== 16'h0) begin
      errors++; $display("FAIL reset_err_count: got %h exp 0", err_count);
    end
`endif
  endtask

  task automatic test_single_write();
    @(posedge clk); #1;
    RREADY = 1'b1; BREADY = 1'b1;
    in_valid = 1'b1; in_is_read = 1'b0; in_resp = DVA; in_locked = 1'b0; in_id = 8'h03;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL wr_in_ready: got %b exp 1", in_ready);
    end
    @(posedge clk); #1;
    idle_inputs();
    checks++;
    if ({BVALID, BID, BRESP, RVALID} !== {1'b1, 4'h3, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL wr_b_beat: BVALID=%b BID=%h BRESP=%b RVALID=%b exp 1 3 00 0", BVALID, BID, BRESP, RVALID);
    end
    @(posedge clk); #1;
    checks++;
    if (BVALID !== 1'b0) begin
      errors++; $display("FAIL wr_b_pop: BVALID got %b exp 0", BVALID);
    end
  endtask

  // Drives len+1 data beats (plus an optional masked beat at mask_pos) with RREADY held low for stall cycles.
  task automatic run_burst(input string name, input logic [7:0] base, input int len,
                           input int stall, input int mask_pos);
    int n_stim = len + 1 + ((mask_pos >= 0) ? 1 : 0);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int first = -1;
    int lastc = -1;
    int u;
    while (got < len + 1 && cyc < 40) begin
      @(posedge clk); #1;
      RREADY = (cyc >= stall);
      if (sent < n_stim) begin
        u = sent - ((mask_pos >= 0 && sent > mask_pos) ? 1 : 0);
        in_valid = 1'b1; in_is_read = 1'b1; in_resp = DVA; in_locked = 1'b0; in_id = 8'h05;
        in_mask  = (sent == mask_pos);
        in_data  = in_mask ? 32'hFFFF_FFFF : DW'(base) + DW'(u);
        in_len   = (sent == 0) ? LW'(len) : 8'hEE;
      end else begin
        idle_inputs();
      end
      #1;
      if (RVALID && RREADY) begin
        checks++;
        if ({RDATA, RLAST, RID, RRESP} !== {DW'(base) + DW'(got), (got == len), 4'h5, 2'b00}) begin
          errors++;
          $display("FAIL %s_beat%0d: RDATA=%h RLAST=%b RID=%h RRESP=%b exp %h %b 5 00",
                   name, got, RDATA, RLAST, RID, RRESP, DW'(base) + DW'(got), (got == len));
        end
        if (first < 0) first = cyc;
        lastc = cyc;
        got++;
      end
      if (stall > 0 && cyc < stall && sent == 2 && in_valid) begin
        checks++;
        if ({in_ready, RVALID, RDATA} !== {1'b0, 1'b1, DW'(base)}) begin
          errors++;
          $display("FAIL %s_backpressure: in_ready=%b RVALID=%b RDATA=%h exp 0 1 %h",
                   name, in_ready, RVALID, RDATA, DW'(base));
        end
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    idle_inputs();
    checks++;
    if (got < len + 1) begin
      errors++; $display("FAIL %s_timeout: got %0d beats exp %0d", name, got, len + 1);
    end else if (stall == 0 && (first != 1 || lastc - first != n_stim - 1)) begin
      errors++;
      $display("FAIL %s_timing: first pop cycle %0d span %0d exp 1 and %0d", name, first, lastc - first, n_stim - 1);
    end
    @(posedge clk); #1;
    checks++;
    if (RVALID !== 1'b0) begin
      errors++; $display("FAIL %s_drained: RVALID got %b exp 0", name, RVALID);
    end
  endtask

  task automatic test_read_burst();
    run_burst("burst", 8'hA0, 3, 0, -1);
  endtask

  task automatic test_backpressure();
    run_burst("stall", 8'hA0, 3, 4, -1);
  endtask

  task automatic test_masked_beat();
    run_burst("mask", 8'hC0, 3, 0, 2);
  endtask

  task automatic test_resp_map();
    logic            t_rd  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [RSPW-1:0] t_rsp [6] = '{DVA, FAIL, 2'd3, DVA, 2'd2, DVA};
    logic            t_lck [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [PIDW-1:0] t_id  [6] = '{8'h01, 8'h02, 8'h07, 8'h0C, 8'h5A, 8'h3F};
    logic [1:0]      t_exp [6] = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
    logic [IDW-1:0]  t_eid [6] = '{4'h1, 4'h2, 4'h7, 4'hC, 4'hA, 4'hF};
`ifdef AXI_NI_RESP_ERR_COUNT_EN
    logic [15:0] err_before;
`endif
    RREADY = 1'b1; BREADY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
`ifdef AXI_NI_RESP_ERR_COUNT_EN
      err_before = err_count;
`endif
      in_valid = 1'b1; in_is_read = t_rd[i]; in_resp = t_rsp[i]; in_locked = t_lck[i];
      in_id = t_id[i]; in_data = DW'(32'h1000 + i); in_len = 8'h00;
      @(posedge clk); #1;
      idle_inputs();
      checks++;
      if (t_rd[i]) begin
        if ({RVALID, RRESP, RID, RLAST, BVALID} !== {1'b1, t_exp[i], t_eid[i], 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL resp_map%0d_r: RVALID=%b RRESP=%b RID=%h RLAST=%b BVALID=%b exp 1 %b %h 1 0",
                   i, RVALID, RRESP, RID, RLAST, BVALID, t_exp[i], t_eid[i]);
        end
      end else begin
        if ({BVALID, BRESP, BID, RVALID} !== {1'b1, t_exp[i], t_eid[i], 1'b0}) begin
          errors++;
          $display("FAIL resp_map%0d_b: BVALID=%b BRESP=%b BID=%h RVALID=%b exp 1 %b %h 0",
                   i, BVALID, BRESP, BID, RVALID, t_exp[i], t_eid[i]);
        end
      end
`ifdef AXI_NI_RESP_ERR_COUNT_EN
      @(posedge clk); #1;
      checks++;
      if (err_count !== err_before + ((t_exp[i] == 2'b10) ? 16'd1 : 16'd0)) begin
        errors++;
        $display("FAIL resp_map%0d_err_count: got %0d exp %0d", i, err_count,
                 err_before + ((t_exp[i] == 2'b10) ? 16'd1 : 16'd0));
      end
`endif
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    RREADY = 1'b0; BREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_is_read = (i < 2); in_resp = DVA; in_locked = 1'b0;
      in_id = 8'h09; in_data = DW'(32'h11 + i); in_len = 8'h03;
      @(posedge clk); #1;
    end
    idle_inputs();
    checks++;
    if ({RVALID, BVALID} !== 2'b11) begin
      errors++; $display("FAIL rstmid_pending: RVALID=%b BVALID=%b exp 1 1", RVALID, BVALID);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_outputs_zero("rstmid_outputs");
    run_burst("post_rst", 8'hD0, 1, 0, -1);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_backpressure();
    test_resp_map();
    test_masked_beat();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi_ni_response_pinout_buf.md
Name: axi_ni_response_pinout_buf

Overview:
- Registered, back-pressured successor to the combinational NI response pinout mask.
- Takes decoded response beats from the initiator NI depacketizer and steers them onto the AXI R or B channel.
- Maps packet response codes to AXI codes, generates RLAST from a per-burst beat counter, and buffers each channel in a 2-entry skid FIFO so RREADY/BREADY back-pressure reaches the NoC side.
- Sits between the depacketizer and the AXI slave-side pins of the initiator NI.

Parameters:
- AXIRDATAWD, 32, R data width (any multiple of 8, 8..1024).
- AXIIDWD, 4, AXI ID width; incoming packet ID is truncated/zero-extended to this.
- LENWD, 8, width of burst length field (beats-1).
- FIFO_DEPTH, 2, entries per channel FIFO (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  response beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_mask  in  1  beat is consumed but dropped (no AXI output, counter unaffected).
- in_is_read  in  1  1 = read data beat, 0 = write response.
- in_locked  in  1  beat belongs to an exclusive (locked) transaction.
- in_resp  in  `PACKETRESPONSEWD  packet response code.
- in_id  in  `PACKETTRANSIDWD  transaction ID.
- in_data  in  AXIRDATAWD  read data.
- in_len  in  LENWD  burst beats-1; sampled only on the first beat of a read burst.
- RID/RDATA/RRESP/RLAST/RVALID  out  AXIIDWD/AXIRDATAWD/2/1/1  AXI read channel.
- RREADY  in  1.
- BID/BRESP/BVALID  out  AXIIDWD/2/1  AXI write response channel.
- BREADY  in  1.

Behaviour:
- Reset: both FIFOs empty, beat counter 0, burst length register 0. RVALID=BVALID=0; RID/RDATA/RRESP/RLAST/BID/BRESP = 0. in_ready=1 in the first cycle after reset deassertion.
- Response mapping (combinational on input, stored in FIFO):
  - DVA & locked -> EXOKAY 2'b01.
  - DVA & ~locked -> OKAY 2'b00.
  - FAIL -> OKAY 2'b00 (failed exclusive).
  - any other code -> SLVERR 2'b10.
- in_ready:
  - When in_is_read=1: R FIFO not full.
  - When in_is_read=0: B FIFO not full.
  - When in_mask=1: always 1.
  - in_ready is a function of registered FIFO state only; it does not depend on RREADY/BREADY in the same cycle.
- Read beat counter:
  - On an accepted unmasked read beat with counter==0, latch in_len into len_q.
  - RLAST for that beat = (counter == current length), where current length = in_len when counter==0, else len_q.
  - Counter increments on each such beat and returns to 0 on the last beat.
  - in_len=0 gives RLAST=1 on every beat.
- FIFOs:
  - Write on accepted, unmasked beat to the selected channel.
  - Pop on xVALID & xREADY.
  - Output is registered head: latency from accept to xVALID is exactly 1 cycle when the FIFO was empty.
  - Simultaneous push and pop on a full FIFO is not possible (in_ready=0). On a non-empty, non-full FIFO, simultaneous push and pop keeps the count unchanged.
  - Sustained throughput: 1 beat/cycle per channel.
- AXI rules:
  - xVALID, once high, stays high with stable payload until xREADY.
  - Ordering within each channel is preserved. No ordering between channels.
- Masked beats: in_ready=1, nothing is written, and counter/len_q are unchanged.
- rst mid-burst: FIFOs and counter clear immediately; pending beats are lost.

Optional Feature:
- Macro: AXI_NI_RESP_ERR_COUNT_EN.
- Defined:
  - Adds output port err_count [15:0].
  - Counts SLVERR responses popped on either channel (R or B handshake with resp 2'b10). Both channels popping SLVERR in the same cycle adds 2.
  - Saturates at 16'hFFFF; cleared by rst.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Single write response, DVA, locked=0, id=3, BREADY=1 -> BVALID high 1 cycle after accept, BID=3, BRESP=2'b00, R channel idle.
- Read burst in_len=3, 4 beats data 0xA0..0xA3, RREADY=1 -> RDATA sequence A0..A3 on consecutive cycles; RLAST=1 only on A3; counter back to 0.
- Same burst with RREADY=0 -> in_ready drops after 2 accepted beats. Releasing RREADY drains A0,A1 then accepts A2,A3; no beat lost or duplicated.
- Exclusive read DVA locked=1 -> RRESP=2'b01. FAIL locked=1 -> 2'b00. Unknown code -> 2'b10 (with macro, err_count increments by 1).
- in_mask=1 beat interleaved mid-burst -> no AXI output, RLAST still on the correct beat.
- rst asserted with 2 R entries and 1 B entry pending -> next cycle RVALID=BVALID=0, outputs zero, a new burst starts with counter=0.
